// File: rtl/pmipsl_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pmipsl_fetch_unit
// Brief    : Instruction fetch stage with a request/grant memory port, a
//            prefetch buffer and flush-on-redirect.
// Revision : 1.0 - initial release
// ============================================================================
module pmipsl_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 17,
  parameter int                PC_STEP  = 2,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [INSTR_W-1:0]       imem_rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INSTR_W-1:0]       out_instr,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [ADDR_W-1:0]        out_pcplus,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     proto_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] c_step    = ADDR_W'(PC_STEP);
  localparam logic [CW-1:0]     c_depth   = CW'(DEPTH);
  localparam logic [CW:0]       c_depth_x = (CW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_fetch_pc;
  logic [ADDR_W-1:0]   r_resp_pc;
  logic [CW-1:0]       r_outstanding;
  logic [CW-1:0]       r_drop_cnt;
  logic [CW-1:0]       w_drop_next;
  logic [CW-1:0]       r_count;
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic                r_proto_err;
  logic [INSTR_W-1:0]  r_mem_instr  [DEPTH];
  logic [ADDR_W-1:0]   r_mem_pc     [DEPTH];
  logic [ADDR_W-1:0]   r_mem_pcplus [DEPTH];

  logic w_redir;
  logic w_rsp;
  logic w_credit;
  logic w_acc;
  logic w_keep;
  logic w_full;
  logic w_pop;
  logic w_push;

  // Redirects during the boot cycle are ignored; the raw pulse still blocks a request.
  assign w_redir  = redirect && (r_state != S_BOOT);
  assign w_rsp    = imem_rvalid && (r_outstanding != '0);
  assign w_credit = ({1'b0, r_count} + {1'b0, r_outstanding} - {1'b0, r_drop_cnt}) < c_depth_x;
  assign imem_req = (r_state != S_BOOT) && !redirect && w_credit;
  assign w_acc    = imem_req && imem_gnt;
  assign w_keep   = w_rsp && !w_redir && (r_drop_cnt == '0);
  assign w_full   = (r_count == c_depth);
  assign w_pop    = out_valid && out_ready;
  assign w_push   = w_keep && (!w_full || w_pop);

  assign imem_addr  = r_fetch_pc;
  assign out_valid  = (r_count != '0);
  assign out_instr  = r_mem_instr[r_rd_ptr];
  assign out_pc     = r_mem_pc[r_rd_ptr];
  assign out_pcplus = r_mem_pcplus[r_rd_ptr];
  assign fifo_count = r_count;
  assign proto_err  = r_proto_err;

  always_comb begin
    w_drop_next  = r_drop_cnt;
    w_state_next = r_state;
    if (w_redir) begin
      w_drop_next = r_outstanding - CW'(w_rsp);
    end else if (w_rsp && (r_drop_cnt != '0)) begin
      w_drop_next = r_drop_cnt - CW'(1);
    end
    case (r_state)
      S_BOOT:         w_state_next = S_RUN;
      S_RUN, S_DROP:  w_state_next = (w_drop_next != '0) ? S_DROP : S_RUN;
      default:        w_state_next = S_BOOT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= S_BOOT;
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_proto_err   <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_drop_cnt    <= w_drop_next;
      r_outstanding <= r_outstanding + CW'(w_acc) - CW'(w_rsp);
      if (imem_rvalid && (r_outstanding == '0)) begin
        r_proto_err <= 1'b1;
      end
      if (w_redir) begin
        r_fetch_pc <= redirect_pc;
        r_resp_pc  <= redirect_pc;
      end else begin
        if (w_acc) begin
          r_fetch_pc <= r_fetch_pc + c_step;
        end
        if (w_push) begin
          r_resp_pc <= r_resp_pc + c_step;
        end
      end
    end
  end

  // Prefetch buffer; the head entry drives the decode outputs directly from flops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_instr[i]  <= '0;
        r_mem_pc[i]     <= '0;
        r_mem_pcplus[i] <= RESET_PC + c_step;
      end
    end else if (w_redir) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_mem_instr[r_wr_ptr]  <= imem_rdata;
        r_mem_pc[r_wr_ptr]     <= r_resp_pc;
        r_mem_pcplus[r_wr_ptr] <= r_resp_pc + c_step;
        r_wr_ptr               <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule
`default_nettype wire

// File: doc/pmipsl_fetch_unit.md
# pmipsl_fetch_unit

Parametrised instruction-fetch stage for the next-generation pipelined MIPS-Lite core. It replaces the single-register PC/IF logic with three pieces: a request/grant instruction-memory port with variable latency, a prefetch buffer of configurable depth, and flush-on-redirect. It sits between instruction memory and the IF/ID register. It feeds decode through a valid/ready handshake and takes branch/jump redirects from the MEM stage.

## Interface
Parameters:
- ADDR_W, 16, width of PC and instruction-memory address.
- INSTR_W, 17, instruction width.
- PC_STEP, 2, byte increment per instruction.
- DEPTH, 4, prefetch buffer entries; power of two, 2..16.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- redirect  in  1  one-cycle pulse; restart fetch at redirect_pc.
- redirect_pc  in  ADDR_W  branch/jump target.
- imem_req  out  1  fetch request valid.
- imem_addr  out  ADDR_W  fetch address; registered.
- imem_gnt  in  1  request accepted this cycle when imem_req=1.
- imem_rvalid  in  1  response valid; responses return in request order, latency ≥1 cycle.
- imem_rdata  in  INSTR_W  response instruction.
- out_valid  out  1  buffer head valid.
- out_ready  in  1  decode accepts head.
- out_instr  out  INSTR_W  head instruction.
- out_pc  out  ADDR_W  address of head instruction.
- out_pcplus  out  ADDR_W  out_pc + PC_STEP, modulo 2^ADDR_W.
- fifo_count  out  $clog2(DEPTH)+1  buffered entries.
- proto_err  out  1  sticky; set when imem_rvalid arrives with no outstanding request.

## Operation
- State machine:
  - BOOT: first cycle after reset release; no requests; go to RUN.
  - RUN: normal fetch; go to DROP on a redirect with responses still in flight.
  - DROP: drop_cnt > 0; arriving responses are discarded and decrement drop_cnt; go to RUN when drop_cnt reaches 0.
  - A redirect is legal in any state except BOOT. A redirect in BOOT is ignored.
- Counters:
  - fetch_pc: next address to request.
  - resp_pc: address of the next kept response.
  - outstanding: accepted requests without a response, 0..DEPTH.
  - drop_cnt: how many of the outstanding responses are stale.
- Credit rule: imem_req = (state != BOOT) && !redirect && (fifo_count + outstanding − drop_cnt < DEPTH). The buffer therefore can never overflow.
- Accepted request (imem_req && imem_gnt): fetch_pc += PC_STEP, wrapping modulo 2^ADDR_W; outstanding += 1.
- Response with drop_cnt == 0: push {imem_rdata, resp_pc} into the buffer; resp_pc += PC_STEP.
- Response with drop_cnt > 0: discard it; drop_cnt −= 1.
- Every response decrements outstanding.
- Pop: out_valid && out_ready removes the head. Push and pop in the same cycle leave fifo_count unchanged, including when the buffer is full.
- Redirect cycle:
  - fetch_pc and resp_pc are loaded with redirect_pc.
  - The buffer is flushed and fifo_count becomes 0.
  - A response arriving in the redirect cycle is discarded.
  - drop_cnt becomes outstanding − imem_rvalid.
  - Any pop in the redirect cycle is still a completed transfer; decode discards it.
  - No request is issued in the redirect cycle.
- Response with outstanding == 0: ignored and proto_err set. proto_err clears only on reset.
- Reset values: imem_req 0, imem_addr RESET_PC, out_valid 0, out_instr 0, out_pc 0, out_pcplus RESET_PC+PC_STEP, fifo_count 0, proto_err 0, state BOOT.
- Reset asserted mid-operation clears all state immediately. In-flight responses arriving after reset release count as protocol errors.

## Timing
- imem_addr changes only on the clock edge after an accepted request or a redirect.
- Buffer outputs are registered: a response pushed in cycle N gives out_valid in cycle N+1.
- Minimum redirect-to-decode latency with a 1-cycle memory: redirect in N, request in N+1, rvalid in N+2, out_valid in N+3.
- Sustained throughput is one instruction per cycle when memory latency < DEPTH and out_ready is held high.
- out_valid and head fields stay stable while out_valid && !out_ready.

## Test plan
- Reset, then gnt=1 with a 1-cycle memory returning instruction = address:
  - first out_valid in cycle 3 after release, with out_pc 0x0000 and out_pcplus 0x0002;
  - afterwards one instruction per cycle at 0x0002, 0x0004, …
- out_ready=0 with DEPTH=4:
  - fifo_count saturates at 4 and imem_req deasserts once fifo_count + outstanding = 4;
  - raising out_ready drains entries in order with none lost.
- 3-cycle memory with 3 requests outstanding, redirect to 0x0100:
  - 3 stale responses are discarded;
  - the first out_instr after the redirect has out_pc 0x0100.
- Redirect coincident with imem_rvalid and a pop, outstanding = 2:
  - drop_cnt = 1 and the buffer is empty the next cycle;
  - the next kept response is tagged redirect_pc.
- ADDR_W=16, redirect to 0xFFFE: fetch addresses go 0xFFFE, then 0x0000; out_pcplus at the head is 0x0000.
- imem_rvalid pulsed with no request outstanding: proto_err = 1 and stays 1 until reset; fifo_count is unchanged.
